// File: rtl/macguffin_pkg.sv
// rtl/macguffin_pkg.sv - shared types, S-box tables and round function for the MacGuffin core
//
// Contents: block_t/word_t/rkey_t, state_t {IDLE,RUN,DONE}, MAX_ROUNDS,
// the eight 6-in/2-out S-boxes, the F function and the 16-bit word rotation.

package macguffin_pkg;

   localparam int MAX_ROUNDS = 32;
   localparam int KEY_W      = 48;

   typedef logic [63:0] block_t;
   typedef logic [15:0] word_t;
   typedef logic [47:0] rkey_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Entry e of S-box n lives at SBOX[n][2e+1:2e].
   localparam logic [7:0][127:0] SBOX = {
      128'hD06E_2B7A_9F43_C815_5A3D_71EC_0B96_F248,
      128'h3C84_A9F1_6E27_D05B_1B96_E4A3_7F08_C2D5,
      128'h6A1F_C308_E79D_25B4_8D52_0FA6_B3E9_471C,
      128'hB7E2_495D_1F0A_6C83_E06B_D92F_37C4_A158,
      128'h2D96_F0C5_8A3E_7B14_C92F_6E01_57A8_DB3C,
      128'hE5A1_7C39_04BF_D826_3F6A_1E90_C57B_28D4,
      128'h4E7B_0A95_D2C6_13F8_6B0E_9D47_A3F1_52C8,
      128'h9C3A_E61B_52D8_7F04_B1E7_2A9C_640D_F35B
   };

   // S-box n reads bit pair n of each keyed word; its 6-bit index is {a,b,c}
   // pairs with a most significant, and its 2-bit output forms F bits 2n+1:2n.
   function automatic word_t mg_f(input word_t w1, input word_t w2,
                                  input word_t w3, input rkey_t k);
      word_t      a;
      word_t      b;
      word_t      c;
      word_t      f;
      logic [5:0] idx;
      a = w1 ^ k[47:32];
      b = w2 ^ k[31:16];
      c = w3 ^ k[15:0];
      f = '0;
      for (int i = 0; i < 8; i++) begin
         idx            = {a[2*i +: 2], b[2*i +: 2], c[2*i +: 2]};
         f[2*i +: 2]    = SBOX[i][{idx, 1'b0} +: 2];
      end
      return f;
   endfunction

   function automatic block_t rotl16(input block_t b);
      return {b[47:0], b[63:48]};
   endfunction

endpackage

// File: rtl/macguffin_iter_core_if.sv
// rtl/macguffin_iter_core_if.sv - key-load and block valid/ready bundle for macguffin_iter_core
//
// master: key-schedule engine + block I/O wrapper side; slave: the core.
// Key port  : key_we, key_addr, key_wdata -> ; <- key_wr_err (sticky)
// Block in  : in_valid, in_decrypt, in_data -> ; <- in_ready
// Block out : <- out_valid, out_data ; out_ready ->
// Status    : <- busy

interface macguffin_iter_core_if;
   import macguffin_pkg::*;

   logic       key_we;
   logic [4:0] key_addr;
   rkey_t      key_wdata;
   logic       key_wr_err;
   logic       in_valid;
   logic       in_ready;
   logic       in_decrypt;
   block_t     in_data;
   logic       out_valid;
   logic       out_ready;
   block_t     out_data;
   logic       busy;

   modport master (
      output key_we, key_addr, key_wdata, in_valid, in_decrypt, in_data, out_ready,
      input  key_wr_err, in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  key_we, key_addr, key_wdata, in_valid, in_decrypt, in_data, out_ready,
      output key_wr_err, in_ready, out_valid, out_data, busy
   );

endinterface

// File: rtl/macguffin_iter_core_round.sv
// rtl/macguffin_iter_core_round.sv - one combinational MacGuffin encrypt round
//
// Ports: blk_i {w3,w2,w1,w0} in, rkey_i round key in,
//        blk_o = {w0 ^ F(w1,w2,w3,k), w3, w2, w1} out.

module macguffin_round
   import macguffin_pkg::*;
(
   input  block_t blk_i,
   input  rkey_t  rkey_i,
   output block_t blk_o
);

   word_t f_val;

   assign f_val = mg_f(blk_i[31:16], blk_i[47:32], blk_i[63:48], rkey_i);
   assign blk_o = {blk_i[15:0] ^ f_val, blk_i[63:16]};

endmodule

// File: rtl/macguffin_iter_core.sv
// rtl/macguffin_iter_core.sv - iterative MacGuffin block cipher core with round-key RAM
//
// Ports: clk, rst_n (async active-low), bus (macguffin_iter_core_if.slave):
//   key write port with sticky key_wr_err, in_* block input handshake,
//   out_* result handshake, busy (RUN or DONE).
// Parameters: ROUNDS (1..32), KW (must equal 48).
// Build option: MACGUFFIN_UNROLL2_EN chains two rounds per cycle (ROUNDS must be even).

module macguffin_iter_core
   import macguffin_pkg::*;
#(
   parameter int ROUNDS = 32,
   parameter int KW     = 48
) (
   input logic                  clk,
   input logic                  rst_n,
   macguffin_iter_core_if.slave bus
);

   if (ROUNDS < 1 || ROUNDS > MAX_ROUNDS) begin : g_bad_rounds
      $error("macguffin_iter_core: ROUNDS must be in 1..32");
   end
   if (KW != KEY_W) begin : g_bad_kw
      $error("macguffin_iter_core: KW must be 48");
   end

`ifdef MACGUFFIN_UNROLL2_EN
   if ((ROUNDS % 2) != 0) begin : g_odd_rounds
      $error("macguffin_iter_core: ROUNDS must be even when unrolled by 2");
   end
   localparam logic [4:0] STEP = 5'd2;
`else
   localparam logic [4:0] STEP = 5'd1;
`endif

   localparam logic [4:0] LAST_KEY = 5'(ROUNDS - 1);
   localparam logic [4:0] LAST_CNT = 5'(ROUNDS - int'(STEP));

   state_t     state_q,      state_d;
   logic [4:0] cnt_q,        cnt_d;
   block_t     blk_q,        blk_d;
   logic       dec_q,        dec_d;
   block_t     out_data_q,   out_data_d;
   logic       out_valid_q,  out_valid_d;
   logic       in_ready_q,   in_ready_d;
   logic       busy_q,       busy_d;
   logic       key_wr_err_q, key_wr_err_d;

   rkey_t      key_ram_q [MAX_ROUNDS];

   logic       key_in_range;
   logic       key_wr_ok;

   // Writes only land while idle so a block never sees its keys change mid-flight.
   assign key_in_range = (32'(bus.key_addr) < 32'(ROUNDS));
   assign key_wr_ok    = bus.key_we && (state_q == IDLE) && key_in_range;

   always_ff @(posedge clk) begin
      if (key_wr_ok) begin
         key_ram_q[bus.key_addr] <= bus.key_wdata;
      end
   end

   // Decrypt runs each round as rotl16 -> encrypt round -> rotl16, which undoes
   // the encrypt round's word shift, and walks the key RAM backwards.
   logic [4:0] key_idx0;
   rkey_t      rkey0;
   block_t     pre0;
   block_t     rnd0;
   block_t     post0;
   block_t     result;

   assign key_idx0 = dec_q ? (LAST_KEY - cnt_q) : cnt_q;
   assign rkey0    = key_ram_q[key_idx0];
   assign pre0     = dec_q ? rotl16(blk_q) : blk_q;

   macguffin_round u_round0 (
      .blk_i  (pre0),
      .rkey_i (rkey0),
      .blk_o  (rnd0)
   );

   assign post0 = dec_q ? rotl16(rnd0) : rnd0;

`ifdef MACGUFFIN_UNROLL2_EN
   logic [4:0] key_idx1;
   rkey_t      rkey1;
   block_t     pre1;
   block_t     rnd1;
   block_t     post1;

   assign key_idx1 = dec_q ? (LAST_KEY - cnt_q - 5'd1) : (cnt_q + 5'd1);
   assign rkey1    = key_ram_q[key_idx1];
   assign pre1     = dec_q ? rotl16(post0) : post0;

   macguffin_round u_round1 (
      .blk_i  (pre1),
      .rkey_i (rkey1),
      .blk_o  (rnd1)
   );

   assign post1  = dec_q ? rotl16(rnd1) : rnd1;
   assign result = post1;
`else
   assign result = post0;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      blk_d        = blk_q;
      dec_d        = dec_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      key_wr_err_d = key_wr_err_q | (bus.key_we & ~key_wr_ok);

      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               blk_d   = bus.in_data;
               dec_d   = bus.in_decrypt;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            blk_d = result;
            if (cnt_q == LAST_CNT) begin
               out_data_d  = result;
               out_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + STEP;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered status follows the next state so it lines up with it.
      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         blk_q        <= '0;
         dec_q        <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         in_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         key_wr_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         blk_q        <= blk_d;
         dec_q        <= dec_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
         key_wr_err_q <= key_wr_err_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.busy       = busy_q;
   assign bus.key_wr_err = key_wr_err_q;

endmodule

// File: doc/macguffin_iter_core.md
Name: macguffin_iter_core

Overview:
Iterative MacGuffin datapath built around one combinational round: one 64-bit block per operation, ROUNDS rounds executed over successive clock cycles.
- Generalises the single combinational round to a full cipher core.
- Configurable round count, encrypt/decrypt mode, internal round-key storage and valid/ready handshakes.
- Sits between the block I/O wrapper and the key-schedule engine, which loads round keys through the key port.

Parameters:
ROUNDS, 32, number of rounds per block; legal range 1..32.
KW, 48, round-key width; fixed by cipher, exposed for package consistency only.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_we  in  1  round-key write strobe
key_addr  in  5  round index 0..ROUNDS-1 being written
key_wdata  in  48  round-key value
key_wr_err  out  1  sticky: a key write was dropped or was out of range
in_valid  in  1  input block valid
in_ready  out  1  core can accept a block
in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled with the block
in_data  in  64  input block
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_data  out  64  result block
busy  out  1  high in RUN and DONE

Behaviour:
- Clock and reset: single clock domain, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, key_wr_err=0, round counter=0. The key RAM is not reset.
- Block words: {w3,w2,w1,w0}, with w3 = bits 63:48.
- F(w1,w2,w3,k): the existing S-box function producing 16 bits.
- Encrypt round: t = w0 ^ F(w1,w2,w3,k); next = {t,w3,w2,w1}.
- Decrypt round: rotate left 16 first, giving {w2,w1,w0,w3}; then apply the encrypt-round XOR to the new w0 with F on the new w1..w3. Result = {w3,w2,w1,w0 ^ F(w1,w2,w3,k)}. This is the exact inverse of the encrypt round.
- Key order:
  - Encrypt uses keys 0..ROUNDS-1.
  - Decrypt uses keys ROUNDS-1..0.
- State machine:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data and in_decrypt, counter=0, go to RUN.
  - RUN: one round per cycle; counter increments. After the round with counter==ROUNDS-1, load the result into out_data, set out_valid=1, go to DONE.
  - DONE: hold out_data stable. On out_ready, clear out_valid and go to IDLE.
- Latency: handshake at cycle N gives out_valid at cycle N+ROUNDS. Throughput is one block per ROUNDS+2 cycles minimum.
- Back-pressure: out_data and out_valid are held indefinitely while out_ready=0. in_ready stays 0.
- Key port, IDLE: key_we with key_addr<ROUNDS writes the RAM in that cycle.
- Key port, RUN/DONE: writes are dropped and set key_wr_err.
- Key port, out of range: key_addr>=ROUNDS is dropped and sets key_wr_err.
- key_wr_err clears only on reset.
- Simultaneous key_we and in_valid in IDLE: the write lands first and the block sees the new key.
- ROUNDS=1: RUN lasts exactly one cycle.
- Reset mid-operation: immediate return to reset values; any partial block is discarded.

Optional Feature:
MACGUFFIN_UNROLL2_EN
- Defined:
  - Two chained round instances per cycle; the counter steps by 2.
  - Latency is ROUNDS/2 cycles.
  - Elaboration error if ROUNDS is odd.
- Undefined: one round per cycle as above.
- Output values are identical in both builds.

Decomposition:
Package macguffin_pkg holds:
- block_t (64-bit), word_t (16-bit), rkey_t (48-bit);
- S-box tables and the F function;
- state enum {IDLE,RUN,DONE};
- MAX_ROUNDS=32.

Instantiate the existing combinational Round module once (twice with MACGUFFIN_UNROLL2_EN). The decrypt pre-rotation is a mux outside it, so no new sub-module is needed.

Test Plan:
- Single round check: ROUNDS=1, key0=48'h0, encrypt 64'h0123456789ABCDEF -> out_data equals the standalone Round output for the same inputs; out_valid 1 cycle after the handshake.
- Round trip: ROUNDS=32, keys k[i]=48'h111111111111*i; encrypt 64'h0123456789ABCDEF, then decrypt the result -> 64'h0123456789ABCDEF; each out_valid exactly 32 cycles after its handshake.
- Back-pressure: out_ready held 0 for 10 cycles -> out_data stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
- Key errors: key_we in RUN -> RAM unchanged (repeat encrypt gives the same result), key_wr_err=1; key_addr=ROUNDS in IDLE -> key_wr_err=1.
- Reset mid-operation: rst_n low at round 5 -> out_valid=0, in_ready=1 immediately; a new block then completes in full latency.
- Build comparison: with MACGUFFIN_UNROLL2_EN and ROUNDS=32 -> same ciphertext as the round-trip test, latency 16.
